// File: rtl/alu_pkg.sv
// Shared opcode encodings, FSM state type and decode helper for the EX-stage ALU.
package alu_pkg;

    localparam logic [4:0] OP_ADD    = 5'd0;
    localparam logic [4:0] OP_SUB    = 5'd1;
    localparam logic [4:0] OP_AND    = 5'd2;
    localparam logic [4:0] OP_OR     = 5'd3;
    localparam logic [4:0] OP_XOR    = 5'd4;
    localparam logic [4:0] OP_SLL    = 5'd5;
    localparam logic [4:0] OP_SRL    = 5'd6;
    localparam logic [4:0] OP_SRA    = 5'd7;
    localparam logic [4:0] OP_SLT    = 5'd8;
    localparam logic [4:0] OP_SLTU   = 5'd9;
    localparam logic [4:0] OP_MUL    = 5'd16;
    localparam logic [4:0] OP_MULH   = 5'd17;
    localparam logic [4:0] OP_MULHSU = 5'd18;
    localparam logic [4:0] OP_MULHU  = 5'd19;
    localparam logic [4:0] OP_DIV    = 5'd20;
    localparam logic [4:0] OP_DIVU   = 5'd21;
    localparam logic [4:0] OP_REM    = 5'd22;
    localparam logic [4:0] OP_REMU   = 5'd23;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic is_muldiv(input logic [4:0] op);
        return (op >= OP_MUL) && (op <= OP_REMU);
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative RV32M multiply/divide datapath: one shift-add or restoring
// shift-subtract step per cycle on operand magnitudes, sign fixed up at the end.
module muldiv_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
)(
    input  logic             clk,
    input  logic             reset,
    input  logic             kill,
    input  logic             start,
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic             running;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] mcand;
    logic             is_div;
    logic             sel_hi;
    logic             sel_rem;
    logic             negate;

    logic             sign_a;
    logic             sign_b;
    logic             start_div;
    logic             start_rem;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;

    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   rem_diff;
    logic             rem_ge;
    logic [WIDTH-1:0] hi_next;
    logic [WIDTH-1:0] lo_next;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0] div_val;
    logic [WIDTH-1:0] div_fix;
    logic             unused_diff_msb;

    // Which operands are treated as signed for this opcode.
    always_comb begin
        sign_a = 1'b0;
        sign_b = 1'b0;
        case (op)
            OP_MULH: begin
                sign_a = a[WIDTH-1];
                sign_b = b[WIDTH-1];
            end
            OP_MULHSU: begin
                sign_a = a[WIDTH-1];
            end
            OP_DIV, OP_REM: begin
                sign_a = a[WIDTH-1];
                sign_b = b[WIDTH-1];
            end
            default: begin
            end
        endcase
    end

    assign start_div = (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
    assign start_rem = (op == OP_REM) || (op == OP_REMU);
    assign mag_a     = sign_a ? -a : a;
    assign mag_b     = sign_b ? -b : b;

    // One iteration step; also feeds the result path so the final step
    // and its sign correction land in the same cycle as done.
    always_comb begin
        add_sum   = {1'b0, hi} + {1'b0, (lo[0] ? mcand : {WIDTH{1'b0}})};
        rem_shift = {hi, lo[WIDTH-1]};
        rem_diff  = rem_shift - {1'b0, mcand};
        rem_ge    = (rem_shift >= {1'b0, mcand});
        if (is_div) begin
            hi_next = rem_ge ? rem_diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
            lo_next = {lo[WIDTH-2:0], rem_ge};
        end else begin
            hi_next = add_sum[WIDTH:1];
            lo_next = {add_sum[0], lo[WIDTH-1:1]};
        end
    end

    assign unused_diff_msb = rem_diff[WIDTH];

    always_comb begin
        prod     = {hi_next, lo_next};
        prod_fix = negate ? -prod : prod;
        div_val  = sel_rem ? hi_next : lo_next;
        div_fix  = negate ? -div_val : div_val;
        if (is_div) begin
            result = div_fix;
        end else begin
            result = sel_hi ? prod_fix[2*WIDTH-1:WIDTH] : prod_fix[WIDTH-1:0];
        end
    end

    assign done = running && (cnt == CNT_LAST);

    // Divide by zero keeps the quotient positive so the all-ones pattern
    // survives; the remainder always takes the dividend's sign.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            running <= 1'b0;
            cnt     <= '0;
            hi      <= '0;
            lo      <= '0;
            mcand   <= '0;
            is_div  <= 1'b0;
            sel_hi  <= 1'b0;
            sel_rem <= 1'b0;
            negate  <= 1'b0;
        end else if (kill) begin
            running <= 1'b0;
            cnt     <= '0;
        end else if (start) begin
            running <= 1'b1;
            cnt     <= '0;
            hi      <= '0;
            lo      <= start_div ? mag_a : mag_b;
            mcand   <= start_div ? mag_b : mag_a;
            is_div  <= start_div;
            sel_hi  <= (op != OP_MUL);
            sel_rem <= start_rem;
            if (start_div) begin
                negate <= start_rem ? sign_a : ((sign_a ^ sign_b) && (b != '0));
            end else begin
                negate <= sign_a ^ sign_b;
            end
        end else if (running) begin
            hi  <= hi_next;
            lo  <= lo_next;
            cnt <= cnt + 1'b1;
            if (cnt == CNT_LAST) begin
                running <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_muldiv_seq.sv
// EX-stage ALU: registered single-cycle ops plus iterative RV32M mul/div
// behind a valid/ready handshake; ready_o low stalls the pipeline.
module alu_muldiv_seq
    import alu_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter bit MULDIV_EN = 1'b1
)(
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic             kill_i,
    input  logic [4:0]       ALU_Operation_i,
    input  logic [WIDTH-1:0] A_i,
    input  logic [WIDTH-1:0] B_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] ALU_Result_o,
    output logic             Zero_o
);

    localparam int SHAMT_W = $clog2(WIDTH);

    state_t             state;
    state_t             state_next;
    logic               accept;
    logic               start_md;
    logic               md_done;
    logic               iter_done;
    logic [WIDTH-1:0]   md_result;
    logic [WIDTH-1:0]   simple_result;
    logic [SHAMT_W-1:0] shamt;

    assign ready_o   = (state != ITER);
    assign accept    = valid_i && ready_o && !kill_i;
    assign start_md  = accept && MULDIV_EN && is_muldiv(ALU_Operation_i);
    assign iter_done = (state == ITER) && md_done && !kill_i;
    assign shamt     = B_i[SHAMT_W-1:0];

    // Anything not decoded here, including a disabled MUL/DIV group, yields zero.
    always_comb begin
        simple_result = '0;
        case (ALU_Operation_i)
            OP_ADD:  simple_result = A_i + B_i;
            OP_SUB:  simple_result = A_i - B_i;
            OP_AND:  simple_result = A_i & B_i;
            OP_OR:   simple_result = A_i | B_i;
            OP_XOR:  simple_result = A_i ^ B_i;
            OP_SLL:  simple_result = A_i << shamt;
            OP_SRL:  simple_result = A_i >> shamt;
            OP_SRA:  simple_result = $unsigned($signed(A_i) >>> shamt);
            OP_SLT:  simple_result = {{(WIDTH-1){1'b0}}, ($signed(A_i) < $signed(B_i))};
            OP_SLTU: simple_result = {{(WIDTH-1){1'b0}}, (A_i < B_i)};
            default: simple_result = '0;
        endcase
    end

    muldiv_iter #(
        .WIDTH (WIDTH)
    ) u_muldiv_iter (
        .clk    (clk),
        .reset  (reset),
        .kill   (kill_i),
        .start  (start_md),
        .op     (ALU_Operation_i),
        .a      (A_i),
        .b      (B_i),
        .done   (md_done),
        .result (md_result)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // DONE is the result-presentation cycle; it accepts like IDLE so a new
    // request can start on the same edge that retires the previous one.
    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: begin
                if (start_md) begin
                    state_next = ITER;
                end else begin
                    state_next = IDLE;
                end
            end
            ITER: begin
                if (kill_i) begin
                    state_next = IDLE;
                end else if (md_done) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_o      <= 1'b0;
            ALU_Result_o <= '0;
            Zero_o       <= 1'b1;
        end else begin
            valid_o <= 1'b0;
            if (accept && !start_md) begin
                valid_o      <= 1'b1;
                ALU_Result_o <= simple_result;
                Zero_o       <= (simple_result == '0);
            end else if (iter_done) begin
                valid_o      <= 1'b1;
                ALU_Result_o <= md_result;
                Zero_o       <= (md_result == '0);
            end
        end
    end

endmodule

// File: doc/alu_muldiv_seq.md
Name: alu_muldiv_seq

Overview:
Parametrised successor to the single-cycle execute-stage ALU. Adds registered single-cycle integer ops and iterative RV32M multiply/divide behind a valid/ready handshake. Sits in EX; the hazard unit stalls the pipeline while ready_o is low. Zero flag is kept for branch compare.

Parameters:
WIDTH, 32, operand/result width; power of two, at least 8.
MULDIV_EN, 1, 1 enables the MUL/DIV group; 0 makes those opcodes invalid.
SHAMT_W, $clog2(WIDTH), localparam: shift-amount bits taken from B_i.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-low reset.
valid_i  in  1  operation request.
ready_o  out  1  block can accept a request this cycle.
kill_i  in  1  synchronous flush of the in-flight operation.
ALU_Operation_i  in  5  opcode.
A_i  in  WIDTH  operand A (rs1).
B_i  in  WIDTH  operand B (rs2 or immediate).
valid_o  out  1  one-cycle pulse: result valid.
ALU_Result_o  out  WIDTH  result, held until the next completion.
Zero_o  out  1  (ALU_Result_o == 0), registered with the result.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE, ready_o=1, valid_o=0, ALU_Result_o=0, Zero_o=1, iteration counter=0.
- Accept when valid_i & ready_o at a rising edge; operands and opcode are captured in that cycle.
- Simple ops, latency 1 (valid_o in the cycle after accept), ready_o stays 1, back-to-back accepts allowed:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR.
  - 5 SLL, 6 SRL, 7 SRA; shift amount = B_i[SHAMT_W-1:0].
  - 8 SLT (signed), 9 SLTU; result is 0 or 1, zero-extended.
  - Arithmetic wraps modulo 2^WIDTH; no overflow flag.
- Multi-cycle ops (MULDIV_EN=1):
  - Opcodes: 16 MUL (low half), 17 MULH (s*s), 18 MULHSU (s*u), 19 MULHU (u*u), 20 DIV, 21 DIVU, 22 REM, 23 REMU.
  - Fixed latency WIDTH+1: accepted at edge N, valid_o high in cycle N+WIDTH+1.
  - ready_o=0 from the cycle after accept until the cycle valid_o is high.
  - ready_o=1 again in the valid_o cycle, so a new request can be accepted on that edge.
- FSM:
  - IDLE -> ITER on accept of a multi-cycle op. Latch magnitudes and sign fixups; counter=0.
  - ITER: one shift-add (MUL) or restoring shift-subtract (DIV) step per cycle; counter+1.
  - ITER -> DONE when counter==WIDTH-1.
  - DONE: apply sign correction, register result, pulse valid_o; -> IDLE.
  - IDLE loops on simple ops and on no request.
- Division special cases use the same fixed latency:
  - Divide by zero: DIV/DIVU quotient = all ones; REM/REMU = A.
  - Signed overflow (A = most negative, B = -1): DIV = A, REM = 0.
- Invalid opcode (including the MUL/DIV group when MULDIV_EN=0): result 0, Zero_o=1, latency 1.
- kill_i=1 at an edge:
  - Aborts ITER/DONE -> IDLE; no valid_o for the killed op; ALU_Result_o keeps its previous value.
  - kill_i has priority over accept in the same cycle: the request is dropped.
- valid_i while ready_o=0 is ignored; the requester must hold the request.
- Reset mid-ITER: immediate return to the reset values; the partial result is discarded.
- No output backpressure: consumers must take the result in the valid_o cycle.

Decomposition:
- Package alu_pkg: opcode localparams (5-bit), state encoding IDLE/ITER/DONE, helper function is_muldiv(op).
- One sub-module, muldiv_iter:
  - Sequential multiply/divide datapath: accumulator, shift register, counter.
  - Interface: start, op, a, b → done, result.
  - Top level keeps the simple-op mux, handshake and flags.

Test Plan:
- Reset: hold reset=0 mid-cycle → ready_o=1, valid_o=0, ALU_Result_o=0, Zero_o=1 immediately, without a clock edge.
- Simple op stream (WIDTH=32), consecutive cycles:
  - ADD 0x7FFFFFFF+1 → 0x80000000.
  - SUB 5-5 → 0, Zero_o=1.
  - SRA 0x80000000 by 4 → 0xF8000000.
  - SLT -1<1 → 1; SLTU -1<1 → 0.
  - Each result valid 1 cycle after accept; ready_o never drops.
- MUL/MULH:
  - MULH 0xFFFFFFFE*0x00000003 → 0xFFFFFFFF, valid_o exactly 33 cycles after accept, ready_o low for 32 cycles.
  - MUL 0x10000*0x10000 → 0.
  - MULHU 0xFFFFFFFF*0xFFFFFFFF → 0xFFFFFFFE.
- Division edge cases:
  - DIV -7/2 → 0xFFFFFFFD; REM -7/2 → 0xFFFFFFFF.
  - DIVU x/0 → 0xFFFFFFFF; REM 0x80000000/0xFFFFFFFF → 0.
  - Every division case completes at latency 33.
- Kill and retry:
  - Start DIVU, assert kill_i at cycle 10 → no valid_o, ALU_Result_o unchanged, ready_o=1 next cycle.
  - Also assert reset=0 mid-ITER → outputs return to reset values.
  - Then ADD 2+3 → 5 with latency 1.
- Back-to-back and invalid ops:
  - Hold valid_i with a second MUL while busy → accepted on the first op's valid_o cycle; second result 33 cycles later.
  - Opcode 31 → result 0, Zero_o=1.
  - MULDIV_EN=0 build: MUL → 0 with latency 1.
